sprite_row_reader: RTL and testbench



---
 rtl/sprite_row_reader_pkg.sv | 34 +++
 rtl/sprite_row_reader_if.sv | 36 +++
 rtl/sprite_row_reader.sv | 123 ++++++++++++
 tb/tb_sprite_row_reader.sv | 344 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sprite_row_reader_pkg.sv
// Shared sprite storage geometry, types and address helper.
// The cache writer, this reader and the renderer all use it.
package sprite_pkg;

    localparam int SPRITE_COUNT     = 8;
    localparam int SPRITE_DIM       = 32;
    localparam int BPP              = 4;
    localparam int BYTES_PER_ROW    = SPRITE_DIM * BPP / 8;
    localparam int BYTES_PER_SPRITE = BYTES_PER_ROW * SPRITE_DIM;
    localparam int ADDR_W           = $clog2(SPRITE_COUNT * BYTES_PER_SPRITE);

    typedef logic [2:0]                         sprite_id_t;
    typedef logic [BPP-1:0]                     pixel_t;
    typedef logic [ADDR_W-1:0]                  sprite_addr_t;
    typedef logic [$clog2(SPRITE_DIM)-1:0]      row_t;
    typedef logic [$clog2(SPRITE_DIM)-1:0]      col_t;
    typedef logic [$clog2(BYTES_PER_ROW)-1:0]   byte_idx_t;

    typedef enum logic [2:0] {
        IDLE,
        READ,
        WAIT,
        EMIT_LO,
        EMIT_HI
    } reader_state_t;

    // Each byte holds two pixels: even column in [3:0], odd column in [7:4].
    function automatic sprite_addr_t sprite_byte_addr(sprite_id_t id, row_t row, byte_idx_t byte_idx);
        return sprite_addr_t'(id) * sprite_addr_t'(BYTES_PER_SPRITE)
             + sprite_addr_t'(row) * sprite_addr_t'(BYTES_PER_ROW)
             + sprite_addr_t'(byte_idx);
    endfunction

endpackage

// File: rtl/sprite_row_reader_if.sv
// Request, RAM and pixel-stream signals of the sprite row reader.
interface sprite_row_reader_if;

    // valid/ready: a transfer happens on a rising clk edge where both are high;
    // the sender holds valid and its payload unchanged until that edge.
    logic                       req_valid;
    logic                       req_ready;
    sprite_pkg::sprite_id_t     req_sprite_id;
    sprite_pkg::row_t           req_row;

    logic                       mem_rd_en;
    sprite_pkg::sprite_addr_t   mem_addr;
    logic [7:0]                 mem_rd_data;

    logic                       pix_valid;
    logic                       pix_ready;
    sprite_pkg::pixel_t         pix_data;
    sprite_pkg::col_t           pix_col;
    logic                       pix_last;

    logic                       busy;
    sprite_pkg::reader_state_t  dbg_state;

    modport slave (
        input  req_valid, req_sprite_id, req_row, mem_rd_data, pix_ready,
        output req_ready, mem_rd_en, mem_addr, pix_valid, pix_data, pix_col,
               pix_last, busy, dbg_state
    );

    modport master (
        output req_valid, req_sprite_id, req_row, mem_rd_data, pix_ready,
        input  req_ready, mem_rd_en, mem_addr, pix_valid, pix_data, pix_col,
               pix_last, busy, dbg_state
    );

endinterface

// File: rtl/sprite_row_reader.sv
// Fetches one row of a sprite from packed 4-bpp storage, one byte at a time,
// and streams it to the renderer as 32 pixels, low nibble first.
module sprite_row_reader #(
    parameter int SPRITE_COUNT = sprite_pkg::SPRITE_COUNT,
    parameter int BPP          = sprite_pkg::BPP
) (
    input logic                clk,
    input logic                rst_n,
    sprite_row_reader_if.slave bus
);
    import sprite_pkg::*;

    localparam logic [3:0] ID_LIMIT = 4'(SPRITE_COUNT);

    if (BPP != 4) begin : g_bpp_check
        $error("sprite_row_reader supports BPP=4 only");
    end

    reader_state_t r_state;
    sprite_id_t    r_id;
    row_t          r_row;
    byte_idx_t     r_cnt;
    logic          r_blank;
    pixel_t        r_hi_nib;

    logic          r_req_ready;
    logic          r_mem_rd_en;
    sprite_addr_t  r_mem_addr;
    logic          r_pix_valid;
    pixel_t        r_pix_data;
    col_t          r_pix_col;
    logic          r_pix_last;
    logic          r_busy;

    logic          w_id_ok;
    logic          w_last_byte;

    assign w_id_ok     = ({1'b0, bus.req_sprite_id} < ID_LIMIT);
    assign w_last_byte = (r_cnt == byte_idx_t'(BYTES_PER_ROW - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_id        <= '0;
            r_row       <= '0;
            r_cnt       <= '0;
            r_blank     <= 1'b0;
            r_hi_nib    <= '0;
            r_req_ready <= 1'b1;
            r_mem_rd_en <= 1'b0;
            r_mem_addr  <= '0;
            r_pix_valid <= 1'b0;
            r_pix_data  <= '0;
            r_pix_col   <= '0;
            r_pix_last  <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (bus.req_valid && r_req_ready) begin
                        r_id        <= bus.req_sprite_id;
                        r_row       <= bus.req_row;
                        r_cnt       <= '0;
                        // Out-of-range ids still walk the row, but as transparent pixels with no RAM traffic.
                        r_blank     <= !w_id_ok;
                        r_mem_rd_en <= w_id_ok;
                        r_mem_addr  <= sprite_byte_addr(bus.req_sprite_id, bus.req_row, '0);
                        r_req_ready <= 1'b0;
                        r_busy      <= 1'b1;
                        r_state     <= READ;
                    end
                end
                READ: begin
                    r_mem_rd_en <= 1'b0;
                    r_state     <= WAIT;
                end
                WAIT: begin
                    r_hi_nib    <= r_blank ? '0 : bus.mem_rd_data[7:4];
                    r_pix_data  <= r_blank ? '0 : bus.mem_rd_data[3:0];
                    r_pix_col   <= {r_cnt, 1'b0};
                    r_pix_valid <= 1'b1;
                    r_state     <= EMIT_LO;
                end
                EMIT_LO: begin
                    if (bus.pix_ready) begin
                        r_pix_data <= r_hi_nib;
                        r_pix_col  <= {r_cnt, 1'b1};
                        r_pix_last <= w_last_byte;
                        r_state    <= EMIT_HI;
                    end
                end
                EMIT_HI: begin
                    if (bus.pix_ready) begin
                        r_pix_valid <= 1'b0;
                        r_pix_last  <= 1'b0;
                        if (w_last_byte) begin
                            r_req_ready <= 1'b1;
                            r_busy      <= 1'b0;
                            r_state     <= IDLE;
                        end else begin
                            r_cnt       <= r_cnt + 1'b1;
                            r_mem_rd_en <= !r_blank;
                            r_mem_addr  <= sprite_byte_addr(r_id, r_row, r_cnt + 1'b1);
                            r_state     <= READ;
                        end
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign bus.req_ready = r_req_ready;
    assign bus.mem_rd_en = r_mem_rd_en;
    assign bus.mem_addr  = r_mem_addr;
    assign bus.pix_valid = r_pix_valid;
    assign bus.pix_data  = r_pix_data;
    assign bus.pix_col   = r_pix_col;
    assign bus.pix_last  = r_pix_last;
    assign bus.busy      = r_busy;
    assign bus.dbg_state = r_state;

endmodule

// File: tb/tb_sprite_row_reader.sv
// Directed bench for sprite_row_reader: reset, row fetch timing, backpressure,
// back-to-back requests, mid-row reset and an out-of-range sprite id.
module tb_sprite_row_reader;
    import sprite_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    sprite_row_reader_if bus ();
    sprite_row_reader_if bus6 ();

    sprite_row_reader u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    sprite_row_reader #(.SPRITE_COUNT(6)) u_dut6 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus6.slave)
    );

    // Storage model: byte n holds n[7:0]; one-cycle registered read.
    logic [7:0] ram [0:4095];
    initial for (int i = 0; i < 4096; i++) ram[i] = 8'(i);

    always @(posedge clk) begin
        if (bus.mem_rd_en)  bus.mem_rd_data  <= ram[bus.mem_addr];
        if (bus6.mem_rd_en) bus6.mem_rd_data <= ram[bus6.mem_addr];
    end

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Observed traffic, sampled on the falling edge.
    logic [9:0]  pix_q[$];
    logic [11:0] addr_q[$];
    int          acc_q[$];
    int          last_q[$];
    int          first_q[$];
    int          rd_cyc_q[$];
    int          stalls = 0;
    logic        prev_stall = 1'b0;
    logic        prev_valid = 1'b0;
    logic [3:0]  prev_data = '0;
    logic [4:0]  prev_col = '0;

    logic [9:0]  pix6_q[$];
    int          acc6 = 0;
    int          rd6 = 0;

    // Expected values built by the bench.
    logic [9:0]  exp_q[$];
    logic [11:0] exp_addr_q[$];

    always @(negedge clk) begin
        if (rst_n) begin
            if (prev_stall) begin
                checks++;
                assert (bus.pix_valid === 1'b1 && bus.pix_data === prev_data && bus.pix_col === prev_col)
                else begin
                    errors++;
                    $error("FAIL stall_hold observed=%b/%h/%0d expected=1/%h/%0d",
                           bus.pix_valid, bus.pix_data, bus.pix_col, prev_data, prev_col);
                end
            end
            if (bus.req_valid && bus.req_ready) acc_q.push_back(cyc);
            if (bus.mem_rd_en) begin
                addr_q.push_back(bus.mem_addr);
                rd_cyc_q.push_back(cyc);
            end
            if (bus.pix_valid && !prev_valid) first_q.push_back(cyc);
            if (bus.pix_valid && bus.pix_ready) begin
                pix_q.push_back({bus.pix_last, bus.pix_col, bus.pix_data});
                if (bus.pix_last) last_q.push_back(cyc);
            end
            if (bus.pix_valid && !bus.pix_ready) stalls++;
            prev_stall = bus.pix_valid && !bus.pix_ready;
            prev_valid = bus.pix_valid;
            prev_data  = bus.pix_data;
            prev_col   = bus.pix_col;

            if (bus6.req_valid && bus6.req_ready) acc6++;
            if (bus6.mem_rd_en) rd6++;
            if (bus6.pix_valid && bus6.pix_ready)
                pix6_q.push_back({bus6.pix_last, bus6.pix_col, bus6.pix_data});
        end else begin
            prev_stall = 1'b0;
            prev_valid = 1'b0;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_q();
        pix_q.delete();
        addr_q.delete();
        acc_q.delete();
        last_q.delete();
        first_q.delete();
        rd_cyc_q.delete();
        exp_q.delete();
        exp_addr_q.delete();
        stalls = 0;
    endtask

    task automatic build_exp(input int base, input bit blank);
        logic [7:0] b;
        for (int k = 0; k < 16; k++) begin
            b = blank ? 8'h00 : 8'(base + k);
            exp_q.push_back({1'b0, 5'(2 * k), b[3:0]});
            exp_q.push_back({k == 15, 5'(2 * k + 1), b[7:4]});
            if (!blank) exp_addr_q.push_back(12'(base + k));
        end
    endtask

    task automatic compare_pixels(input string tag);
        logic [9:0] got;
        logic [9:0] exp_v;
        while (exp_q.size() > 0) begin
            exp_v = exp_q.pop_front();
            if (pix_q.size() > 0) got = pix_q.pop_front();
            else got = 'x;
            check($sformatf("%s_pix_c%0d", tag, exp_v[8:4]), 32'(got), 32'(exp_v));
        end
        check({tag, "_extra_pix"}, pix_q.size(), 0);
    endtask

    task automatic compare_addrs(input string tag);
        logic [11:0] got;
        logic [11:0] exp_v;
        while (exp_addr_q.size() > 0) begin
            exp_v = exp_addr_q.pop_front();
            if (addr_q.size() > 0) got = addr_q.pop_front();
            else got = 'x;
            check($sformatf("%s_addr_%0d", tag, exp_v), 32'(got), 32'(exp_v));
        end
        check({tag, "_extra_reads"}, addr_q.size(), 0);
    endtask

    task automatic send_req(input logic [2:0] id, input logic [4:0] row, input string tag);
        int n;
        int k;
        n = acc_q.size();
        k = 0;
        @(posedge clk); #1;
        bus.req_valid = 1'b1;
        bus.req_sprite_id = id;
        bus.req_row = row;
        while (acc_q.size() == n && k < 50) begin
            @(negedge clk); #1;
            k++;
        end
        check({tag, "_accept"}, 32'(acc_q.size() > n), 1);
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
    endtask

    task automatic wait_pix(input int n, input int budget, input string tag);
        int k;
        k = 0;
        while (pix_q.size() < n && k < budget) begin
            @(negedge clk); #1;
            k++;
        end
        check({tag, "_done_in_time"}, 32'(pix_q.size() >= n), 1);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_req_ready"}, 32'(bus.req_ready), 1);
        check({tag, "_mem_rd_en"}, 32'(bus.mem_rd_en), 0);
        check({tag, "_mem_addr"},  32'(bus.mem_addr), 0);
        check({tag, "_pix_valid"}, 32'(bus.pix_valid), 0);
        check({tag, "_pix_data"},  32'(bus.pix_data), 0);
        check({tag, "_pix_col"},   32'(bus.pix_col), 0);
        check({tag, "_pix_last"},  32'(bus.pix_last), 0);
        check({tag, "_busy"},      32'(bus.busy), 0);
        check({tag, "_state"},     32'(bus.dbg_state), 32'(IDLE));
    endtask

    initial begin
        int k;
        bus.req_valid = 1'b0;
        bus.req_sprite_id = '0;
        bus.req_row = '0;
        bus.pix_ready = 1'b0;
        bus6.req_valid = 1'b0;
        bus6.req_sprite_id = '0;
        bus6.req_row = '0;
        bus6.pix_ready = 1'b0;

        // Reset values, during and after reset.
        repeat (3) @(negedge clk);
        #1;
        check_reset_outputs("rst_hold");
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk); #1;
        check_reset_outputs("rst_release");

        // Basic fetch: id=2, row=5 -> base 1104, bytes 0x50..0x5F.
        clear_q();
        bus.pix_ready = 1'b1;
        send_req(3'd2, 5'd5, "basic");
        wait_pix(32, 200, "basic");
        check("basic_first_valid_lat", 32'(first_q[0] - acc_q[0]), 3);
        check("basic_first_read_lat", 32'(rd_cyc_q[0] - acc_q[0]), 1);
        check("basic_row_cycles", 32'(last_q[0] - acc_q[0]), 64);
        for (int i = 1; i < 16; i++)
            check($sformatf("basic_read_gap_%0d", i), 32'(rd_cyc_q[i] - rd_cyc_q[i-1]), 4);
        check("basic_col1_data", 32'(pix_q[1][3:0]), 5);
        build_exp(1104, 1'b0);
        compare_pixels("basic");
        compare_addrs("basic");

        // Backpressure: id=3, row=10 -> base 1696, bytes 0xA0..0xAF.
        repeat (2) @(posedge clk);
        clear_q();
        send_req(3'd3, 5'd10, "bp");
        k = 0;
        while (pix_q.size() < 32 && k < 400) begin
            @(posedge clk); #1;
            bus.pix_ready = ($urandom_range(0, 2) != 0);
            k++;
        end
        check("bp_done_in_time", 32'(pix_q.size() >= 32), 1);
        bus.pix_ready = 1'b1;
        check("bp_saw_stalls", 32'(stalls > 0), 1);
        build_exp(1696, 1'b0);
        compare_pixels("bp");
        compare_addrs("bp");

        // Back-to-back: id=0,row=0 then id=7,row=31 with req_valid held.
        repeat (2) @(posedge clk);
        clear_q();
        @(posedge clk); #1;
        bus.req_valid = 1'b1;
        bus.req_sprite_id = 3'd0;
        bus.req_row = 5'd0;
        k = 0;
        while (acc_q.size() < 1 && k < 50) begin
            @(negedge clk); #1;
            k++;
        end
        check("b2b_first_accept", 32'(acc_q.size()), 1);
        @(posedge clk); #1;
        bus.req_sprite_id = 3'd7;
        bus.req_row = 5'd31;
        k = 0;
        while (acc_q.size() < 2 && k < 150) begin
            @(negedge clk); #1;
            k++;
        end
        check("b2b_second_accept", 32'(acc_q.size()), 2);
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        wait_pix(64, 200, "b2b");
        check("b2b_accept_gap", 32'(acc_q[1] - last_q[0]), 1);
        check("b2b_second_first_addr", 32'(addr_q[16]), 4080);
        build_exp(0, 1'b0);
        build_exp(4080, 1'b0);
        compare_pixels("b2b");
        compare_addrs("b2b");

        // Reset at column 9 of id=4,row=2, then a clean id=1,row=0 fetch.
        repeat (2) @(posedge clk);
        clear_q();
        send_req(3'd4, 5'd2, "mid");
        k = 0;
        while (!(bus.pix_valid && bus.pix_col == 5'd9) && k < 100) begin
            @(negedge clk); #1;
            k++;
        end
        check("mid_reached_col9", 32'(bus.pix_valid && bus.pix_col == 5'd9), 1);
        #1;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("mid_rst");
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (3) @(posedge clk);
        clear_q();
        send_req(3'd1, 5'd0, "post");
        wait_pix(32, 200, "post");
        build_exp(512, 1'b0);
        compare_pixels("post");
        compare_addrs("post");

        // Out-of-range id on the SPRITE_COUNT=6 instance.
        repeat (2) @(posedge clk);
        clear_q();
        pix6_q.delete();
        acc6 = 0;
        rd6 = 0;
        bus6.pix_ready = 1'b1;
        @(posedge clk); #1;
        bus6.req_valid = 1'b1;
        bus6.req_sprite_id = 3'd6;
        bus6.req_row = 5'd3;
        k = 0;
        while (acc6 == 0 && k < 50) begin
            @(negedge clk); #1;
            k++;
        end
        check("inv_accept", 32'(acc6), 1);
        @(posedge clk); #1;
        bus6.req_valid = 1'b0;
        k = 0;
        while (pix6_q.size() < 32 && k < 200) begin
            @(negedge clk); #1;
            k++;
        end
        check("inv_done_in_time", 32'(pix6_q.size() >= 32), 1);
        repeat (3) @(negedge clk);
        #1;
        check("inv_idle_after", 32'(bus6.busy), 0);
        check("inv_no_reads", 32'(rd6), 0);
        pix_q = pix6_q;
        build_exp(0, 1'b1);
        compare_pixels("inv");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
